// File: rtl/scalar_mem_pkg.sv
// Shared types and default sizes for the scalar memory controller and its RAM.
package scalar_mem_pkg;

  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_DATA_W    = 24;
  localparam int DEF_MEM_DEPTH = 2 ** 16;

  // Wide enough for the largest load value, RD_LAT-1 = 2.
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_scalar.sv
// Single-port RAM with RD_LAT read pipeline stages; reads of words at or
// above DEPTH return zero and writes there are dropped.
module ram_scalar
  import scalar_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              rden,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe_q [RD_LAT];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = ({1'b0, address} < DEPTH_LIM);
  assign idx      = address[IDX_W-1:0];

  // NOTE: the storage array has no reset; clearing every word would turn the
  // RAM into a huge flop bank. Only control state is ever reset.
  always_ff @(posedge clk) begin
    if (wren && in_range) begin
      mem[idx] <= data;
    end
    if (rden) begin
      pipe_q[0] <= in_range ? mem[idx] : '0;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q = pipe_q[RD_LAT-1];

endmodule

// File: rtl/scalar_mem_ctrl.sv
// Request/response controller for a scalar synchronous RAM with RD_LAT read
// latency. Define SCALAR_MEM_CTRL_ADDR_CHECK_EN to reject addresses >= MEM_DEPTH.
module scalar_mem_ctrl
  import scalar_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

`ifdef SCALAR_MEM_CTRL_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              rden_q, rden_d;
  logic              wren_q, wren_d;
  logic              out_of_range;

  // Constant-false when range checking is compiled out, so every address is forwarded.
  assign out_of_range = ADDR_CHECK && ({1'b0, req_addr} >= DEPTH_LIM);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    err_d   = err_q;
    rden_d  = 1'b0;
    wren_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_wdata;
          if (out_of_range) begin
            state_d = RESP;
            valid_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_we) begin
            state_d = WRITE;
            wren_d  = 1'b1;
          end else begin
            state_d = READ;
            rden_d  = 1'b1;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(RD_LAT - 1);
      end
      WAIT: begin
        // mem_q is valid on the cycle the counter reaches zero.
        if (cnt_q == '0) begin
          rdata_d = mem_q;
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge _d value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_rden    = rden_q;
  assign mem_wren    = wren_q;

endmodule

// File: doc/scalar_mem_ctrl.md
SCALAR_MEM_CTRL -- requirements
Module: scalar_mem_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 24, address width; DATA_W, default 24, data width; RD_LAT, default 1, RAM clock edges from sampling mem_rden to valid mem_q (1..3); MEM_DEPTH, default 2**16, number of legal words.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, named clk and rst.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  out-of-range access flag
- mem_address  out  ADDR_W  to RAM address
- mem_data  out  DATA_W  to RAM data
- mem_rden  out  1  to RAM rden
- mem_wren  out  1  to RAM wren
- mem_q  in  DATA_W  from RAM q

Function
REQ-004 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_ready SHALL equal (state == IDLE).
REQ-005 The FSM SHALL have states IDLE, WRITE, READ, WAIT and RESP.
REQ-006 IDLE SHALL go to WRITE on an accepted write and to READ on an accepted read; otherwise it SHALL remain in IDLE.
REQ-007 When a request is accepted, req_addr and req_wdata SHALL be registered onto mem_address and mem_data, which SHALL hold until the next acceptance.
REQ-008 WRITE SHALL last exactly one cycle with mem_wren=1 and mem_rden=0, then return to IDLE; a write SHALL produce no response.
REQ-009 READ SHALL last exactly one cycle with mem_rden=1, then go to WAIT with a down-counter loaded with RD_LAT-1.
REQ-010 WAIT SHALL decrement the counter each cycle; at counter==0 it SHALL capture mem_q into rsp_rdata and go to RESP.
REQ-011 rsp_valid SHALL rise exactly RD_LAT+1 cycles after the acceptance edge.
REQ-012 RESP SHALL hold rsp_valid=1 and keep rsp_rdata stable until rsp_ready=1, then go to IDLE.
REQ-013 A new request SHALL be accepted no earlier than the cycle after the response handshake; there SHALL be no read/write overlap.
REQ-014 mem_rden and mem_wren SHALL never both be 1, and both SHALL be 0 in IDLE, WAIT and RESP.
REQ-015 Addresses SHALL pass through unmodified; there SHALL be no wrap-around or arithmetic on the address.

Reset
REQ-016 While rst=1 at an edge, the state SHALL be IDLE and the outputs SHALL be: req_ready=1 after reset; rsp_valid=0; rsp_err=0; mem_rden=0; mem_wren=0; mem_address=0; mem_data=0; rsp_rdata=0; counter=0.
REQ-017 A reset asserted mid-read SHALL abandon the transaction with no response; a late mem_q SHALL be ignored.

Configuration
REQ-018 The macro SCALAR_MEM_CTRL_ADDR_CHECK_EN SHALL control address range checking.
- Defined: an accepted request with req_addr >= MEM_DEPTH SHALL NOT assert mem_rden or mem_wren. It SHALL go directly to RESP with rsp_err=1 and rsp_rdata=0 for both reads and writes; the write error response SHALL use the same handshake.
- Undefined: rsp_err SHALL be tied to 0 and all addresses SHALL be forwarded.

Structure
REQ-019 A shared package scalar_mem_pkg SHALL hold the state enum type, the default ADDR_W/DATA_W constants and the MEM_DEPTH default.
REQ-020 There SHALL be no sub-module; the latency counter SHALL be inline.
REQ-021 The verification bench SHALL connect the block directly to ram_scalar.

Verification
REQ-022 Write then read:
- Write addr 0x001000, data 0xABCDEF -> mem_wren high exactly 1 cycle.
- Read 0x001000 -> rsp_rdata=0xABCDEF, rsp_valid at acceptance+RD_LAT+1.
REQ-023 Back-to-back: write 0x001001=0x123456 and 0x001002=0x654321, read both -> responses in order, req_ready low during every non-IDLE cycle.
REQ-024 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no RAM strobes.
REQ-025 Reset: rst=1 in WAIT -> next cycle IDLE, rsp_valid=0; a following read of 0x001000 returns 0xABCDEF normally.
REQ-026 Range check, with the macro defined: read 0x010000 -> rsp_err=1, rsp_rdata=0, no mem_rden. Without the macro: mem_rden pulses and rsp_err=0.
REQ-027 Run each scenario with RD_LAT=1 and RD_LAT=2.
